alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//  Execute stage of the single-cycle processor: ALU-control decode, 32-bit ALU with a
//  registered N/V/Z status register, and the PC+4 / branch-target adders. Drives the
//  write-back ALU result, the beq zero flag and the bvf/ben flag-based branch condition.
//  One clock domain; clock is clk. Reset is asynchronous and active-high, named reset.
// PARAMETERS
//  WIDTH   32  datapath width (result, operands, PC)
//  PC_INC  4   constant added to pc for pc_plus4
// PORTS
//  clk            in   1      rising-edge clock
//  reset          in   1      async active-high; clears the status register
//  aluop1         in   1      R-type: decode funct
//  aluop2         in   1      subtract (beq compare)
//  aluop3         in   1      OR (ori)
//  funct          in   4      instr[3:0]
//  a              in   WIDTH  operand A (rs)
//  b              in   WIDTH  operand B (rt or sign-extended imm)
//  jump           in   1      1 = hold the status register this cycle
//  brcond         in   2      00 none, 01 bvf (V), 10 ben (N), 11 none
//  pc             in   WIDTH  current PC
//  sextad         in   WIDTH  sign-extended offset, already shifted left 2
//  result         out  WIDTH  ALU result
//  zout           out  1      combinational: result == 0
//  gout           out  4      decoded ALU operation
//  control_out    out  1      flag-branch condition from the registered flags
//  flags          out  3      registered {N,V,Z}
//  pc_plus4       out  WIDTH  pc + PC_INC
//  branch_target  out  WIDTH  pc_plus4 + sextad
// BEHAVIOUR
//  - ALU-op decode (combinational), priority aluop1 > aluop2 > aluop3 > default:
//    aluop1=1, funct: 0000 ADD, 0010 SUB, 0100 AND, 0101 OR, 0111 NOR, 1010 SLT; any other funct -> ADD.
//    aluop2=1 -> SUB; aluop3=1 -> OR; all zero -> ADD (lw/sw address).
//  - gout codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
//    An undefined gout gives result 0.
//  - Arithmetic is modulo 2^WIDTH and carry is discarded. SLT compares signed and returns 1 or 0.
//  - Next flags: Z = (result==0); N = result[WIDTH-1].
//    V for ADD = a,b same sign and result sign differs from a.
//    V for SUB = a,b signs differ and result sign differs from a.
//    V = 0 for all other ops.
//  - Status register: at each rising clk with jump=0, flags <= next flags.
//    With jump=1, flags hold. reset=1 forces flags=000 immediately and holds them while asserted.
//  - control_out = (brcond==01 & flags.V) | (brcond==10 & flags.N). It reads flags from the
//    previous instruction (1-cycle latency) and never the current result.
//  - result, zout, gout, pc_plus4 and branch_target are purely combinational with zero latency.
//    Both adders wrap modulo 2^WIDTH.
//  - Reset mid-operation affects only the flags. Combinational outputs track inputs throughout.
// TESTING
//  1. aluop=100, funct=0000, a=7FFFFFFF, b=1 -> result 80000000, gout 0010;
//     after clk edge flags = {1,1,0}.
//  2. aluop=010, a=b=5 -> result 0, zout 1; next edge flags={0,0,1}; brcond=01 -> control_out 0.
//  3. Step 1 result registered, then jump=1 with a=b=0 ADD over an edge -> flags stay {1,1,0};
//     brcond=10 -> control_out 1.
//  4. aluop=100, funct=1010: a=FFFFFFFF, b=1 -> result 1; swap operands -> result 0.
//     funct=0111, a=b=0 -> result FFFFFFFF.
//  5. pc=FFFFFFFC, sextad=8 -> pc_plus4 0, branch_target 8; pc=0, sextad=FFFFFFF8 -> branch_target FFFFFFFC.
//  6. Flags={1,1,0}, assert reset between edges -> flags 000 and control_out 0 immediately, no clock needed.

Source files
------------

// File: rtl/alu_exec_unit_if.sv
// Execute-stage bus: decode controls, operands, PC inputs and the ALU/branch results.
// The master drives operands and controls; the slave (execute unit) returns results.
interface alu_exec_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             aluop1;
  logic             aluop2;
  logic             aluop3;
  logic [3:0]       funct;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             jump;
  logic [1:0]       brcond;
  logic [WIDTH-1:0] pc;
  logic [WIDTH-1:0] sextad;
  logic [WIDTH-1:0] result;
  logic             zout;
  logic [3:0]       gout;
  logic             control_out;
  logic [2:0]       flags;
  logic [WIDTH-1:0] pc_plus4;
  logic [WIDTH-1:0] branch_target;

  modport master (
    output aluop1, aluop2, aluop3, funct, a, b, jump, brcond, pc, sextad,
    input  result, zout, gout, control_out, flags, pc_plus4, branch_target
  );

  modport slave (
    input  aluop1, aluop2, aluop3, funct, a, b, jump, brcond, pc, sextad,
    output result, zout, gout, control_out, flags, pc_plus4, branch_target
  );
endinterface

// File: rtl/alu_exec_unit.sv
// Execute stage: ALU-control decode, 32-bit ALU, registered {N,V,Z} status flags,
// flag-based branch condition, and the PC+4 / branch-target adders.
module alu_exec_unit #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned PC_INC = 4
) (
  input logic          clk,
  input logic          reset,
  alu_exec_unit_if.slave bus
);

  localparam logic [3:0] G_AND = 4'b0000;
  localparam logic [3:0] G_OR  = 4'b0001;
  localparam logic [3:0] G_ADD = 4'b0010;
  localparam logic [3:0] G_SUB = 4'b0110;
  localparam logic [3:0] G_SLT = 4'b0111;
  localparam logic [3:0] G_NOR = 4'b1100;

  localparam int unsigned MSB = WIDTH - 1;

  logic [3:0]       op;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             slt;
  logic [WIDTH-1:0] res;
  logic             v_next;
  logic [2:0]       flags_d;
  logic [2:0]       flags_q;

  // ALU-control decode, priority aluop1 > aluop2 > aluop3 > address add
  always_comb begin
    op = G_ADD;
    if (bus.aluop1) begin
      case (bus.funct)
        4'b0000: op = G_ADD;
        4'b0010: op = G_SUB;
        4'b0100: op = G_AND;
        4'b0101: op = G_OR;
        4'b0111: op = G_NOR;
        4'b1010: op = G_SLT;
        default: op = G_ADD;
      endcase
    end else if (bus.aluop2) begin
      op = G_SUB;
    end else if (bus.aluop3) begin
      op = G_OR;
    end
  end

  assign sum  = bus.a + bus.b;
  assign diff = bus.a - bus.b;
  assign slt  = $signed(bus.a) < $signed(bus.b);

  always_comb begin
    res    = '0;
    v_next = 1'b0;
    case (op)
      G_AND: res = bus.a & bus.b;
      G_OR:  res = bus.a | bus.b;
      G_ADD: begin
        res    = sum;
        v_next = (bus.a[MSB] == bus.b[MSB]) && (sum[MSB] != bus.a[MSB]);
      end
      G_SUB: begin
        res    = diff;
        v_next = (bus.a[MSB] != bus.b[MSB]) && (diff[MSB] != bus.a[MSB]);
      end
      G_SLT: res = WIDTH'(slt);
      G_NOR: res = ~(bus.a | bus.b);
      default: res = '0;
    endcase
  end

  assign flags_d = {res[MSB], v_next, (res == '0)};

  // Status register: jump holds the flags of the previous ALU instruction
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags_q <= '0;
    end else if (!bus.jump) begin
      flags_q <= flags_d;
    end
  end

  assign bus.result        = res;
  assign bus.zout          = (res == '0);
  assign bus.gout          = op;
  assign bus.flags         = flags_q;
  assign bus.control_out   = ((bus.brcond == 2'b01) && flags_q[1]) ||
                             ((bus.brcond == 2'b10) && flags_q[2]);
  assign bus.pc_plus4      = bus.pc + WIDTH'(PC_INC);
  assign bus.branch_target = bus.pc_plus4 + bus.sextad;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit with hand-computed expected values.
module tb_alu_exec_unit;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;

  alu_exec_unit_if #(.WIDTH(32)) bus ();

  alu_exec_unit #(.WIDTH(32), .PC_INC(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic set_op(input logic [2:0] aluop, input logic [3:0] fn,
                        input logic [31:0] av, input logic [31:0] bv);
    bus.aluop1 = aluop[2];
    bus.aluop2 = aluop[1];
    bus.aluop3 = aluop[0];
    bus.funct  = fn;
    bus.a      = av;
    bus.b      = bv;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    reset      = 1'b1;
    bus.jump   = 1'b0;
    bus.brcond = 2'b01;
    bus.pc     = '0;
    bus.sextad = '0;
    set_op(3'b100, 4'b0000, 32'h7FFF_FFFF, 32'h1);
    tick();
    check("reset_flags", 32'(bus.flags), 32'h0);
    check("reset_ctrl", 32'(bus.control_out), 32'h0);
    @(negedge clk);
    reset = 1'b0;

    // ADD overflow into negative
    set_op(3'b100, 4'b0000, 32'h7FFF_FFFF, 32'h1);
    check("add_ovf_result", bus.result, 32'h8000_0000);
    check("add_gout", 32'(bus.gout), 32'h2);
    tick();
    check("add_ovf_flags", 32'(bus.flags), 32'h6);

    // jump holds flags from the ADD
    @(negedge clk);
    bus.jump = 1'b1;
    set_op(3'b100, 4'b0000, 32'h0, 32'h0);
    check("jump_zout", 32'(bus.zout), 32'h1);
    tick();
    check("jump_hold_flags", 32'(bus.flags), 32'h6);
    bus.brcond = 2'b10;
    #1 check("ben_ctrl", 32'(bus.control_out), 32'h1);
    bus.brcond = 2'b01;
    #1 check("bvf_ctrl", 32'(bus.control_out), 32'h1);
    bus.brcond = 2'b11;
    #1 check("none_ctrl", 32'(bus.control_out), 32'h0);

    // beq compare: SUB to zero
    @(negedge clk);
    bus.jump = 1'b0;
    set_op(3'b010, 4'b0000, 32'h5, 32'h5);
    check("beq_result", bus.result, 32'h0);
    check("beq_zout", 32'(bus.zout), 32'h1);
    check("sub_gout", 32'(bus.gout), 32'h6);
    tick();
    check("beq_flags", 32'(bus.flags), 32'h1);
    bus.brcond = 2'b01;
    #1 check("bvf_after_beq", 32'(bus.control_out), 32'h0);

    // SUB overflow: V set, N clear
    @(negedge clk);
    set_op(3'b100, 4'b0010, 32'h8000_0000, 32'h1);
    check("sub_ovf_result", bus.result, 32'h7FFF_FFFF);
    tick();
    check("sub_ovf_flags", 32'(bus.flags), 32'h2);

    // SLT signed, NOR, AND, OR, undefined funct
    @(negedge clk);
    set_op(3'b100, 4'b1010, 32'hFFFF_FFFF, 32'h1);
    check("slt_true", bus.result, 32'h1);
    check("slt_gout", 32'(bus.gout), 32'h7);
    set_op(3'b100, 4'b1010, 32'h1, 32'hFFFF_FFFF);
    check("slt_false", bus.result, 32'h0);
    set_op(3'b100, 4'b0111, 32'h0, 32'h0);
    check("nor_result", bus.result, 32'hFFFF_FFFF);
    check("nor_gout", 32'(bus.gout), 32'hC);
    set_op(3'b100, 4'b0100, 32'hF0F0_1234, 32'h0FF0_FF00);
    check("and_result", bus.result, 32'h00F0_1200);
    set_op(3'b100, 4'b0101, 32'hF000_0001, 32'h0000_0010);
    check("or_result", bus.result, 32'hF000_0011);
    set_op(3'b100, 4'b1111, 32'h3, 32'h4);
    check("undef_funct_add", bus.result, 32'h7);
    set_op(3'b001, 4'b0000, 32'h00FF_0000, 32'h0000_1234);
    check("ori_result", bus.result, 32'h00FF_1234);
    check("ori_gout", 32'(bus.gout), 32'h1);
    set_op(3'b011, 4'b0000, 32'h9, 32'h4);
    check("aluop2_over_aluop3", bus.result, 32'h5);
    set_op(3'b000, 4'b0010, 32'h100, 32'h20);
    check("default_add", bus.result, 32'h120);
    tick();
    check("pos_add_flags", 32'(bus.flags), 32'h0);

    // PC adders wrap
    bus.pc     = 32'hFFFF_FFFC;
    bus.sextad = 32'h8;
    #1 check("pc_plus4_wrap", bus.pc_plus4, 32'h0);
    check("btarget_fwd", bus.branch_target, 32'h8);
    bus.pc     = 32'h0;
    bus.sextad = 32'hFFFF_FFF8;
    #1 check("btarget_back", bus.branch_target, 32'hFFFF_FFFC);

    // async reset between edges
    @(negedge clk);
    set_op(3'b100, 4'b0000, 32'h7FFF_FFFF, 32'h1);
    tick();
    check("pre_reset_flags", 32'(bus.flags), 32'h6);
    bus.brcond = 2'b10;
    #2 reset = 1'b1;
    #1 check("async_reset_flags", 32'(bus.flags), 32'h0);
    check("async_reset_ctrl", 32'(bus.control_out), 32'h0);
    check("reset_result_live", bus.result, 32'h8000_0000);
    tick();
    check("reset_held_flags", 32'(bus.flags), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    check("post_reset_flags", 32'(bus.flags), 32'h6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
